instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: DEPTH, default 4, instruction buffer entries (power of two, 2..16).
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-low.
REQ-005 redirect_i  input  1  branch/jump taken; flush buffer and restart fetch.
REQ-006 redirect_pc_i  input  32  new fetch address, valid with redirect_i.
REQ-007 mem_req_o  output  1  instruction memory read request.
REQ-008 mem_addr_o  output  32  word-aligned fetch address, valid with mem_req_o.
REQ-009 mem_ack_i  input  1  memory completes the request this cycle.
REQ-010 mem_rdata_i  input  32  instruction word, valid with mem_ack_i.
REQ-011 instr_valid_o  output  1  buffer head holds a valid instruction.
REQ-012 instr_o  output  32  buffer head instruction.
REQ-013 instr_pc_o  output  32  address of instr_o.
REQ-014 instr_ready_i  input  1  CPU consumes the head when instr_valid_o=1.
REQ-015 count_o  output  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-016 FSM states: IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is discarded).
REQ-017 IDLE->REQ when count + pending < DEPTH and no redirect; mem_req_o=1 and mem_addr_o=fetch_pc from that cycle.
REQ-018 mem_req_o and mem_addr_o are held stable until the cycle mem_ack_i=1; at most one request outstanding.
REQ-019 REQ with mem_ack_i=1: push {mem_rdata_i, mem_addr_o}, fetch_pc += 4 (32-bit wrap), next state REQ if room remains, else IDLE.
REQ-020 Pop when instr_valid_o & instr_ready_i; push and pop in the same cycle leave count unchanged.
REQ-021 instr_valid_o = (count_o != 0); instr_o/instr_pc_o are the head entry, driven combinationally from storage.
REQ-022 redirect_i=1: next cycle count=0 and fetch_pc={redirect_pc_i[31:2],2'b00}; a pop in that cycle is ignored.
REQ-023 Redirect in REQ without ack -> DROP; redirect in REQ with ack -> ack data discarded, next state IDLE.
REQ-024 DROP keeps old mem_req_o/mem_addr_o until mem_ack_i, then discards the data and enters IDLE; redirect in DROP only updates fetch_pc.
REQ-025 Base latency: instr_valid_o rises the cycle after mem_ack_i.
REQ-026 Full buffer: no new request; an in-flight ack always has a reserved slot (no overflow possible).

Reset
REQ-027 rst_i low: state IDLE, fetch_pc=RESET_PC, count_o=0, mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, all immediately (asynchronous).
REQ-028 Reset during an outstanding request abandons it; a later mem_ack_i with no request is ignored.
REQ-029 First request issued in the first cycle after rst_i deasserts.

Configuration
REQ-030 Macro IFU_BYPASS_EN defined: when the buffer is empty and mem_ack_i=1 with no redirect, mem_rdata_i/mem_addr_o appear on instr_o/instr_pc_o with instr_valid_o=1 in the same cycle; if instr_ready_i=1 the word is not stored.
REQ-031 IFU_BYPASS_EN undefined: no combinational path from mem_ack_i/mem_rdata_i to outputs; latency per REQ-025.

Structure
REQ-032 Package ifu_pkg holds the state enum (IDLE, REQ, DROP), INSTR_W=32, PC_W=32 and the default RESET_PC.
REQ-033 Buffer is a sub-module ifu_fifo (sync FIFO, DEPTH entries of {pc, instr}, push/pop/flush, count output); FSM and fetch_pc stay in instr_fetch_unit.

Verification
REQ-034 Reset release, memory acks 1 cycle after each request, ready=1 -> instr_pc_o sequence 0x0,0x4,0x8 with matching data.
REQ-035 ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC), then mem_req_o=0 and count_o=4; one pop -> request 0x10 issued next cycle.
REQ-036 Redirect to 0x103 while request 0x8 outstanding -> 0x8 held until ack, data dropped, next request 0x100, count_o=0.
REQ-037 Redirect to 0x40 in the same cycle as ack and pop -> nothing pushed, count_o=0, next request 0x40.
REQ-038 rst_i low mid-request -> mem_req_o=0 and instr_valid_o=0 in that cycle; after release, first request at RESET_PC.
REQ-039 IFU_BYPASS_EN, empty buffer, ack with data 0x2002_0001 -> instr_valid_o=1 and instr_o=0x2002_0001 in the ack cycle, count_o stays 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, DROP} ifu_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifu_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries; flush wins over push/pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  ifu_entry_t                   wdata_i,
  output ifu_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ifu_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM feeding ifu_fifo; one memory request in flight at a time.
// Optional IFU_BYPASS_EN forwards an ack straight to the outputs when the buffer is empty.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [PC_W-1:0]            redirect_pc_i,
  output logic                       mem_req_o,
  output logic [PC_W-1:0]            mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [INSTR_W-1:0]         mem_rdata_i,
  output logic                       instr_valid_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [PC_W-1:0]            instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH+1);

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  ifu_entry_t      head;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     cnt_nxt;
  logic            fifo_vld, ack_take, byp_vld, byp_take, push, pop, room;

  assign fifo_vld = (fifo_cnt != '0);
  assign ack_take = (state_q == REQ) && mem_ack_i && !redirect_i;
`ifdef IFU_BYPASS_EN
  assign byp_vld  = ack_take && !fifo_vld;
`else
  assign byp_vld  = 1'b0;
`endif
  assign byp_take = byp_vld && instr_ready_i;
  assign push     = ack_take && !byp_take;
  assign pop      = fifo_vld && instr_ready_i && !redirect_i;
  // Occupancy after this edge; a new request is only launched when its slot is guaranteed.
  assign cnt_nxt  = {1'b0, fifo_cnt} + (CW+1)'(push) - (CW+1)'(pop);
  assign room     = cnt_nxt < (CW+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = word_align(redirect_pc_i);
        end else if (room) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetch_pc_d = word_align(redirect_pc_i);
          state_d    = mem_ack_i ? IDLE : DROP;
        end else if (mem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (room) begin
            addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect_i) fetch_pc_d = word_align(redirect_pc_i);
        if (mem_ack_i)  state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i ('{pc: addr_q, instr: mem_rdata_i}),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign mem_req_o     = (state_q != IDLE);
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = fifo_vld || byp_vld;
  assign instr_o       = byp_vld ? mem_rdata_i : head.instr;
  assign instr_pc_o    = byp_vld ? addr_q      : head.pc;
  assign count_o       = fifo_cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=4, RESET_PC=0); honours IFU_BYPASS_EN.
module tb_instr_fetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic [2:0]  count_o;

  int n_chk = 0;
  int n_err = 0;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_req",   32'(mem_req_o), 32'h0);
    chk("rst_addr",  mem_addr_o, 32'h0);
    chk("rst_vld",   32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc",    instr_pc_o, 32'h0);
    chk("rst_cnt",   32'(count_o), 32'h0);
    rst_i = 1'b1;
    step();
    chk("first_req",  32'(mem_req_o), 32'h1);
    chk("first_addr", mem_addr_o, 32'h0);

    // streaming with ready=1: pcs 0,4,8
    instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("s_addr", mem_addr_o, 32'(4*k));
      step();
      chk("s_hold", mem_addr_o, 32'(4*k));
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h1000_0000 + 32'(4*k);
`ifdef IFU_BYPASS_EN
      #1;
      chk("s_byp_vld", 32'(instr_valid_o), 32'h1);
      chk("s_byp_pc",  instr_pc_o, 32'(4*k));
      step();
      mem_ack_i = 1'b0;
      chk("s_byp_cnt", 32'(count_o), 32'h0);
`else
      step();
      mem_ack_i = 1'b0;
      chk("s_vld",   32'(instr_valid_o), 32'h1);
      chk("s_pc",    instr_pc_o, 32'(4*k));
      chk("s_instr", instr_o, 32'h1000_0000 + 32'(4*k));
`endif
      chk("s_next", mem_addr_o, 32'(4*k+4));
      if (k < 2) step();
    end

    // asynchronous reset while request 0xC is outstanding
    rst_i = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req_o), 32'h0);
    chk("arst_vld", 32'(instr_valid_o), 32'h0);
    chk("arst_cnt", 32'(count_o), 32'h0);
    step();
    rst_i = 1'b1;
    instr_ready_i = 1'b0;
    step();
    chk("rel_addr", mem_addr_o, 32'h0);

    // fill with ready=0
    for (int k = 0; k < 4; k++) begin
      chk("f_req",  32'(mem_req_o), 32'h1);
      chk("f_addr", mem_addr_o, 32'(4*k));
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h1000_0000 + 32'(4*k);
      step();
      mem_ack_i = 1'b0;
    end
    chk("full_req",   32'(mem_req_o), 32'h0);
    chk("full_cnt",   32'(count_o), 32'h4);
    chk("full_pc",    instr_pc_o, 32'h0);
    chk("full_instr", instr_o, 32'h1000_0000);
    step();
    chk("full_req2", 32'(mem_req_o), 32'h0);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk("pop_req",  32'(mem_req_o), 32'h1);
    chk("pop_addr", mem_addr_o, 32'h10);
    chk("pop_cnt",  32'(count_o), 32'h3);
    chk("pop_pc",   instr_pc_o, 32'h4);

    // fill, then redirect to 0x8 from IDLE
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("f2_cnt", 32'(count_o), 32'h4);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8;
    step();
    redirect_i = 1'b0;
    chk("rd1_cnt", 32'(count_o), 32'h0);
    step();
    chk("rd1_addr", mem_addr_o, 32'h8);

    // redirect to 0x103 while 0x8 outstanding
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    step();
    redirect_i = 1'b0;
    chk("drop_req",  32'(mem_req_o), 32'h1);
    chk("drop_addr", mem_addr_o, 32'h8);
    step();
    chk("drop_hold", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hBAD0_0008;
    step();
    mem_ack_i = 1'b0;
    chk("drop_cnt", 32'(count_o), 32'h0);
    chk("drop_vld", 32'(instr_valid_o), 32'h0);
    chk("drop_idle", 32'(mem_req_o), 32'h0);
    step();
    chk("rd2_addr", mem_addr_o, 32'h100);

    // redirect to 0x40 with ack and pop in the same cycle
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h1000_0100;
    step();
    chk("pre_cnt", 32'(count_o), 32'h1);
    mem_rdata_i = 32'h1000_0104;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    instr_ready_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    chk("rda_cnt", 32'(count_o), 32'h0);
    chk("rda_req", 32'(mem_req_o), 32'h0);
    step();
    chk("rda_addr", mem_addr_o, 32'h40);

    // ack on empty buffer: bypass vs registered latency
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h2002_0001;
    #1;
`ifdef IFU_BYPASS_EN
    chk("byp_vld",   32'(instr_valid_o), 32'h1);
    chk("byp_instr", instr_o, 32'h2002_0001);
    chk("byp_pc",    instr_pc_o, 32'h40);
`else
    chk("nb_vld", 32'(instr_valid_o), 32'h0);
`endif
    instr_ready_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
`ifdef IFU_BYPASS_EN
    chk("byp_cnt", 32'(count_o), 32'h0);
`else
    chk("nb_cnt",   32'(count_o), 32'h1);
    chk("nb_instr", instr_o, 32'h2002_0001);
`endif
    chk("end_addr", mem_addr_o, 32'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
